ddr2_rd_burst_assembler: RTL
============================

# ddr2_rd_burst_assembler

Downstream stage of the read-data FIFO. Each `read_data_valid` cycle delivers one rise/fall beat pair; this block packs BURST_LEN beats into one user-width word and tags it with the ID of the read command that produced it. It presents the word on a valid/ready user port through a small output buffer, and flags tag and data overflow or underflow conditions.

## Interface
- MEMORY_WIDTH, 8, width of one DDR beat (one rise or fall sample)
- BURST_LEN, 4, beats per burst; even, 4 or 8
- TAG_WIDTH, 4, read command tag width
- TAG_DEPTH, 8, tag FIFO entries; power of two
- OUT_DEPTH, 4, output buffer entries; power of two
- clk  input  1  system clock; all logic on the rising edge
- reset  input  1  synchronous, active-high reset
- read_data_valid  input  1  beat pair valid this cycle
- read_data_fifo_rise  input  MEMORY_WIDTH  earlier beat of the pair
- read_data_fifo_fall  input  MEMORY_WIDTH  later beat of the pair
- cmd_tag_push  input  1  controller issued a read; push cmd_tag
- cmd_tag  input  TAG_WIDTH  tag of the issued read
- cmd_tag_full  output  1  tag FIFO full
- rd_flush  input  1  discard the partially assembled burst
- user_valid  output  1  output buffer head valid
- user_ready  input  1  consumer accepts head
- user_data  output  MEMORY_WIDTH*BURST_LEN  assembled word
- user_tag  output  TAG_WIDTH  tag of user_data
- tag_overflow  output  1  sticky: push while tag FIFO full
- tag_underflow  output  1  sticky: word completed with tag FIFO empty
- data_overflow  output  1  sticky: word dropped because output buffer full

## Operation
- **Beat counter:** pair_cnt counts 0..BURST_LEN/2-1 and advances on each read_data_valid.
  - Pair k writes rise to bits [2k*W +: W] and fall to [(2k+1)*W +: W], where W = MEMORY_WIDTH. Beat 0 occupies the LSBs.
  - When read_data_valid arrives at pair_cnt = BURST_LEN/2-1, the word is complete. pair_cnt wraps to 0.
- **Completion:** the completed word, including the final pair captured that cycle, is pushed into the output buffer together with the popped tag FIFO head.
  - Tag FIFO empty at completion: tag 0 is used and tag_underflow is set.
- **Tag FIFO:** first-in first-out order.
  - Push while full is ignored and sets tag_overflow. Push and pop in the same cycle while full is accepted.
  - Push and pop in the same cycle while empty: the pop sees empty (underflow); the pushed tag is stored.
- **Output buffer:** show-ahead. user_valid = not empty. A pop occurs when user_valid && user_ready.
  - Completion while full with no pop in the same cycle: the word is dropped, data_overflow is set, and the tag is still popped.
  - Completion while full with a pop in the same cycle: the word is accepted.
- **rd_flush:** forces pair_cnt to 0 and discards the partial word. Buffers and the tag FIFO are unaffected.
  - If rd_flush and read_data_valid are high in the same cycle, rd_flush wins and the pair is discarded.
- **Sticky flags:** cleared only by reset.
- **No backpressure:** the block never stalls read_data_valid; read data cannot be throttled.
- **Reset:** clears pair_cnt and all pointers. Reset values: user_valid 0, user_data 0, user_tag 0, cmd_tag_full 0, all sticky flags 0. Reset asserted mid-burst discards all state.

## Timing
- Word completes at edge N, when the last read_data_valid pair is sampled.
  - If the buffer was empty: user_valid = 1 with the word and tag visible after edge N.
  - Minimum latency from the last pair to user_valid is 1 cycle.
- Pop at edge P: the next entry, or user_valid = 0, is visible after edge P.
- cmd_tag_full reflects the count after the current edge's push/pop and is registered.
- Back-to-back bursts need no idle cycle between them; throughput is one word per BURST_LEN/2 cycles.
- user_data and user_tag are stable while user_valid && !user_ready.

## Test plan
- **Single burst (BL4, W=8):** reset, push tag 3, then valid pairs (rise 0x11, fall 0x22), (0x33, 0x44) -> one cycle later user_valid = 1, user_data = 0x44332211, user_tag = 3; pop clears user_valid.
- **Backpressure:** user_ready = 0; push tags 1..5; feed 5 bursts -> 4 words buffered in tag order 1..4, the 5th is dropped, data_overflow = 1. Draining returns tags 1,2,3,4 with their data intact.
- **Underflow:** burst with no tag pushed -> user_tag = 0, tag_underflow = 1. A subsequent tagged burst is delivered normally.
- **Tag overflow:** 9 pushes with no reads -> cmd_tag_full = 1 after the 8th push, tag_overflow = 1 after the 9th. The first 8 tags come out in order.
- **Flush:** one pair, then rd_flush, then two full pairs (0xAA/0xBB, 0xCC/0xDD) -> a single word 0xDDCCBBAA is delivered; no partial word is emitted.
- **Reset mid-burst:** assert reset after one pair with a word buffered -> all outputs are 0 next cycle; a fresh burst assembles from beat 0.

Source files
------------

// File: rtl/ddr2_rd_burst_assembler.sv
// DDR2 read burst assembler: packs rise/fall beat pairs into user words,
// tags each word with its read command ID and buffers it for the consumer.
module ddr2_rd_burst_assembler #(
    parameter int MEMORY_WIDTH = 8,
    parameter int BURST_LEN    = 4,
    parameter int TAG_WIDTH    = 4,
    parameter int TAG_DEPTH    = 8,
    parameter int OUT_DEPTH    = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              read_data_valid,
    input  logic [MEMORY_WIDTH-1:0]           read_data_fifo_rise,
    input  logic [MEMORY_WIDTH-1:0]           read_data_fifo_fall,
    input  logic                              cmd_tag_push,
    input  logic [TAG_WIDTH-1:0]              cmd_tag,
    output logic                              cmd_tag_full,
    input  logic                              rd_flush,
    output logic                              user_valid,
    input  logic                              user_ready,
    output logic [MEMORY_WIDTH*BURST_LEN-1:0] user_data,
    output logic [TAG_WIDTH-1:0]              user_tag,
    output logic                              tag_overflow,
    output logic                              tag_underflow,
    output logic                              data_overflow
);

    localparam int PAIRS = BURST_LEN / 2;
    localparam int CW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int DW    = MEMORY_WIDTH * BURST_LEN;
    localparam int TAW   = $clog2(TAG_DEPTH);
    localparam int OAW   = $clog2(OUT_DEPTH);
    localparam logic [CW-1:0] LAST = CW'(PAIRS - 1);

    logic [CW-1:0]        pair_cnt_q, pair_cnt_d;
    logic [DW-1:0]        asm_q, word_d;
    logic                 beat_en, complete;

    logic [TAG_WIDTH-1:0] tag_mem [TAG_DEPTH];
    logic [TAW:0]         tag_wp_q, tag_rp_q;
    logic                 tag_empty, tag_full, tag_push, tag_pop;
    logic [TAG_WIDTH-1:0] comp_tag;

    logic [DW-1:0]        dat_mem [OUT_DEPTH];
    logic [TAG_WIDTH-1:0] otag_mem [OUT_DEPTH];
    logic [OAW:0]         out_wp_q, out_rp_q;
    logic                 out_empty, out_full, out_push, out_pop;

    logic                 tag_ovf_q, tag_unf_q, dat_ovf_q;

    // A flush in the same cycle as a beat pair discards that pair.
    assign beat_en  = read_data_valid && !rd_flush;
    assign complete = beat_en && (pair_cnt_q == LAST);

    assign tag_empty = (tag_wp_q == tag_rp_q);
    assign tag_full  = (tag_wp_q[TAW] != tag_rp_q[TAW]) &&
                       (tag_wp_q[TAW-1:0] == tag_rp_q[TAW-1:0]);
    assign tag_pop   = complete && !tag_empty;
    assign tag_push  = cmd_tag_push && (!tag_full || tag_pop);
    assign comp_tag  = tag_empty ? '0 : tag_mem[tag_rp_q[TAW-1:0]];

    assign out_empty = (out_wp_q == out_rp_q);
    assign out_full  = (out_wp_q[OAW] != out_rp_q[OAW]) &&
                       (out_wp_q[OAW-1:0] == out_rp_q[OAW-1:0]);
    assign out_pop   = !out_empty && user_ready;
    assign out_push  = complete && (!out_full || out_pop);

    assign cmd_tag_full  = tag_full;
    assign user_valid    = !out_empty;
    assign user_data     = out_empty ? '0 : dat_mem[out_rp_q[OAW-1:0]];
    assign user_tag      = out_empty ? '0 : otag_mem[out_rp_q[OAW-1:0]];
    assign tag_overflow  = tag_ovf_q;
    assign tag_underflow = tag_unf_q;
    assign data_overflow = dat_ovf_q;

    // Merge the current pair into the partial word and step the pair count.
    always_comb begin
        word_d     = asm_q;
        pair_cnt_d = pair_cnt_q;
        word_d[2 * int'(pair_cnt_q) * MEMORY_WIDTH +: MEMORY_WIDTH] =
            read_data_fifo_rise;
        word_d[(2 * int'(pair_cnt_q) + 1) * MEMORY_WIDTH +: MEMORY_WIDTH] =
            read_data_fifo_fall;
        if (rd_flush) begin
            pair_cnt_d = '0;
        end else if (read_data_valid) begin
            pair_cnt_d = complete ? '0 : pair_cnt_q + 1'b1;
        end
    end

    // Control state: pair counter, partial word, pointers and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            pair_cnt_q <= '0;
            asm_q      <= '0;
            tag_wp_q   <= '0;
            tag_rp_q   <= '0;
            out_wp_q   <= '0;
            out_rp_q   <= '0;
            tag_ovf_q  <= 1'b0;
            tag_unf_q  <= 1'b0;
            dat_ovf_q  <= 1'b0;
        end else begin
            pair_cnt_q <= pair_cnt_d;
            if (beat_en) asm_q <= word_d;
            if (tag_push) tag_wp_q <= tag_wp_q + 1'b1;
            if (tag_pop) tag_rp_q <= tag_rp_q + 1'b1;
            if (out_push) out_wp_q <= out_wp_q + 1'b1;
            if (out_pop) out_rp_q <= out_rp_q + 1'b1;
            if (cmd_tag_push && !tag_push) tag_ovf_q <= 1'b1;
            if (complete && tag_empty) tag_unf_q <= 1'b1;
            if (complete && !out_push) dat_ovf_q <= 1'b1;
        end
    end

    // Storage arrays; contents are only observed through valid pointers.
    always_ff @(posedge clk) begin
        if (tag_push) tag_mem[tag_wp_q[TAW-1:0]] <= cmd_tag;
        if (out_push) begin
            dat_mem[out_wp_q[OAW-1:0]]  <= word_d;
            otag_mem[out_wp_q[OAW-1:0]] <= comp_tag;
        end
    end

endmodule
